// File: rtl/letter_catcher.sv
// Falling-letter table: spawns descriptors into free slots, moves them on frame ticks,
// clears them on matching keys (hit) or at the bottom line (miss), and keeps the score.
module letter_catcher #(
  parameter int          N_SLOTS    = 8,
  parameter int          IDX_W      = 3,
  parameter logic [8:0]  X_LIMIT    = 9'd470,
  parameter logic [15:0] MISS_LIMIT = 16'd10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spawn_valid,
  input  logic [7:0]         spawn_ch,
  input  logic [2:0]         spawn_speed,
  input  logic [8:0]         spawn_x,
  input  logic [9:0]         spawn_y,
  output logic               spawn_ready,
  input  logic               frame_tick,
  input  logic               key_valid,
  input  logic [7:0]         key_code,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_active,
  output logic [7:0]         rd_ch,
  output logic [8:0]         rd_x,
  output logic [9:0]         rd_y,
  output logic [N_SLOTS-1:0] active_mask,
  output logic               hit_pulse,
  output logic [15:0]        score,
  output logic [15:0]        miss,
  output logic [15:0]        wrong,
  output logic               game_over
);

  typedef enum logic {RUN, OVER} state_t;

  localparam logic [9:0] LIMIT_W = {1'b0, X_LIMIT};

  state_t state, state_next;

  logic [N_SLOTS-1:0] active;
  logic [7:0]         slot_ch    [N_SLOTS];
  logic [2:0]         slot_speed [N_SLOTS];
  logic [8:0]         slot_x     [N_SLOTS];
  logic [9:0]         slot_y     [N_SLOTS];

  logic               running, do_spawn, do_key, do_tick, hit_found, do_hit, do_wrong;
  logic [7:0]         key_folded;
  logic [N_SLOTS-1:0] spawn_vec, hit_vec, clear_vec, move_vec;
  logic [9:0]         sum [N_SLOTS];
  logic [IDX_W:0]     n_miss;
  logic [16:0]        miss_sum;
  logic [15:0]        miss_next, score_next, wrong_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == RUN && miss_next >= MISS_LIMIT) state_next = OVER;
  end

  always_comb begin
    spawn_ready = (state == RUN) && (active != '1);
    game_over   = (state == OVER);
  end

  // Keys are matched against the pre-tick table, so a hit slot never also counts as a miss.
  always_comb begin
    running    = (state == RUN);
    do_spawn   = spawn_valid && spawn_ready;
    do_key     = running && key_valid;
    do_tick    = running && frame_tick;
    key_folded = (key_code >= 8'h61 && key_code <= 8'h7A) ? key_code - 8'd32 : key_code;
    spawn_vec  = '0;
    hit_vec    = '0;
    hit_found  = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        spawn_vec    = '0;
        spawn_vec[i] = 1'b1;
      end
      if (active[i] && slot_ch[i] == key_folded) begin
        hit_vec    = '0;
        hit_vec[i] = 1'b1;
        hit_found  = 1'b1;
      end
    end
    spawn_vec = do_spawn ? spawn_vec : '0;
    do_hit    = do_key && hit_found;
    do_wrong  = do_key && !hit_found;
    hit_vec   = do_hit ? hit_vec : '0;
    n_miss    = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      sum[i]       = {1'b0, slot_x[i]} + {7'd0, slot_speed[i]};
      clear_vec[i] = hit_vec[i];
      move_vec[i]  = 1'b0;
      if (do_tick && active[i] && !hit_vec[i]) begin
        if (sum[i] >= LIMIT_W) begin
          clear_vec[i] = 1'b1;
          n_miss       = n_miss + {{IDX_W{1'b0}}, 1'b1};
        end else begin
          move_vec[i] = 1'b1;
        end
      end
    end
    miss_sum   = {1'b0, miss} + {{(16 - IDX_W){1'b0}}, n_miss};
    miss_next  = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    score_next = (do_hit && score != 16'hFFFF) ? score + 16'd1 : score;
    wrong_next = (do_wrong && wrong != 16'hFFFF) ? wrong + 16'd1 : wrong;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        slot_ch[i]    <= '0;
        slot_speed[i] <= '0;
        slot_x[i]     <= '0;
        slot_y[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (spawn_vec[i]) begin
          active[i]     <= 1'b1;
          slot_ch[i]    <= spawn_ch;
          slot_speed[i] <= spawn_speed;
          slot_x[i]     <= spawn_x;
          slot_y[i]     <= spawn_y;
        end else begin
          if (clear_vec[i]) active[i] <= 1'b0;
          if (move_vec[i])  slot_x[i] <= sum[i][8:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score     <= '0;
      miss      <= '0;
      wrong     <= '0;
      hit_pulse <= 1'b0;
    end else begin
      score     <= score_next;
      miss      <= miss_next;
      wrong     <= wrong_next;
      hit_pulse <= do_hit;
    end
  end

  // Inactive slots read back as all zero regardless of stale field contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_active <= 1'b0;
      rd_ch     <= '0;
      rd_x      <= '0;
      rd_y      <= '0;
    end else if (active[rd_idx]) begin
      rd_active <= 1'b1;
      rd_ch     <= slot_ch[rd_idx];
      rd_x      <= slot_x[rd_idx];
      rd_y      <= slot_y[rd_idx];
    end else begin
      rd_active <= 1'b0;
      rd_ch     <= '0;
      rd_x      <= '0;
      rd_y      <= '0;
    end
  end

  assign active_mask = active;

endmodule

// File: tb/tb_letter_catcher.sv
// Bench for letter_catcher: a directed vector table, hand-written corner sequences and
// randomized episodes checked against a slot-list reference model.
module tb_letter_catcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        spawn_valid;
  logic [7:0]  spawn_ch;
  logic [2:0]  spawn_speed;
  logic [8:0]  spawn_x;
  logic [9:0]  spawn_y;
  logic        spawn_ready;
  logic        frame_tick;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [2:0]  rd_idx;
  logic        rd_active;
  logic [7:0]  rd_ch;
  logic [8:0]  rd_x;
  logic [9:0]  rd_y;
  logic [7:0]  active_mask;
  logic        hit_pulse;
  logic [15:0] score, miss, wrong;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  letter_catcher dut (
    .clk(clk), .rst(rst),
    .spawn_valid(spawn_valid), .spawn_ch(spawn_ch), .spawn_speed(spawn_speed),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_ready(spawn_ready),
    .frame_tick(frame_tick), .key_valid(key_valid), .key_code(key_code),
    .rd_idx(rd_idx), .rd_active(rd_active), .rd_ch(rd_ch), .rd_x(rd_x), .rd_y(rd_y),
    .active_mask(active_mask), .hit_pulse(hit_pulse),
    .score(score), .miss(miss), .wrong(wrong), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference model: a plain list of letters with integer positions.
  bit m_act [8];
  int m_ch [8], m_spd [8], m_x [8], m_y [8];
  int m_score, m_miss, m_wrong;
  bit m_over, m_hit;
  int e_rd_act, e_rd_ch, e_rd_x, e_rd_y;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic bit model_ready();
    if (m_over) return 1'b0;
    for (int i = 0; i < 8; i++) if (!m_act[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] model_mask();
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = m_act[i];
    return m;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_act[i] = 0; m_ch[i] = 0; m_spd[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_score = 0; m_miss = 0; m_wrong = 0; m_over = 0; m_hit = 0;
  endfunction

  function automatic void model_step();
    int spawn_slot = -1;
    int hit_slot = -1;
    int lost = 0;
    int k, nx;
    e_rd_act = m_act[rd_idx];
    e_rd_ch  = m_act[rd_idx] ? m_ch[rd_idx] : 0;
    e_rd_x   = m_act[rd_idx] ? m_x[rd_idx]  : 0;
    e_rd_y   = m_act[rd_idx] ? m_y[rd_idx]  : 0;
    m_hit = 0;
    if (spawn_valid && model_ready())
      for (int i = 7; i >= 0; i--) if (!m_act[i]) spawn_slot = i;
    if (!m_over) begin
      if (key_valid) begin
        k = int'(key_code);
        if (k >= 97 && k <= 122) k = k - 32;
        for (int i = 7; i >= 0; i--) if (m_act[i] && m_ch[i] == k) hit_slot = i;
        if (hit_slot >= 0) begin
          m_score = sat16(m_score + 1);
          m_hit = 1;
        end else begin
          m_wrong = sat16(m_wrong + 1);
        end
      end
      if (frame_tick)
        for (int i = 0; i < 8; i++)
          if (m_act[i] && i != hit_slot) begin
            nx = m_x[i] + m_spd[i];
            if (nx >= 470) begin
              m_act[i] = 0;
              lost++;
            end else m_x[i] = nx;
          end
      if (hit_slot >= 0) m_act[hit_slot] = 0;
      m_miss = sat16(m_miss + lost);
      if (m_miss >= 10) m_over = 1;
      if (spawn_slot >= 0) begin
        m_act[spawn_slot] = 1;
        m_ch[spawn_slot]  = int'(spawn_ch);
        m_spd[spawn_slot] = int'(spawn_speed);
        m_x[spawn_slot]   = int'(spawn_x);
        m_y[spawn_slot]   = int'(spawn_y);
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [7:0] ch, input logic [2:0] spd,
                               input logic [8:0] x, input logic [9:0] y, input logic tick,
                               input logic kv, input logic [7:0] key);
    spawn_valid = sv; spawn_ch = ch; spawn_speed = spd; spawn_x = x; spawn_y = y;
    frame_tick = tick; key_valid = kv; key_code = key;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 8'h00, 3'd0, 9'd0, 10'd0, 1'b0, 1'b0, 8'h00);
    rd_idx = 3'd0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    idleInputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle();
  endtask

  typedef struct {
    logic        sv;
    logic [7:0]  ch;
    logic [2:0]  spd;
    logic [8:0]  x;
    logic        tick;
    logic        kv;
    logic [7:0]  key;
    logic [7:0]  exp_mask;
    logic [15:0] exp_score;
    logic [15:0] exp_miss;
    logic [15:0] exp_wrong;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [13];

  initial begin
    rst = 1'b0;
    idleInputs();
    //           sv  ch     spd   x       tick kv  key    mask   score miss wrong hit
    vecs[0]  = '{1, 8'h41, 3'd2, 9'd0,   0,   0,  8'h00, 8'h01, 0,    0,   0,    0};
    vecs[1]  = '{1, 8'h43, 3'd1, 9'd468, 0,   0,  8'h00, 8'h03, 0,    0,   0,    0};
    vecs[2]  = '{1, 8'h43, 3'd0, 9'd100, 0,   0,  8'h00, 8'h07, 0,    0,   0,    0};
    vecs[3]  = '{0, 8'h00, 3'd0, 9'd0,   0,   1,  8'h63, 8'h05, 1,    0,   0,    1};
    vecs[4]  = '{0, 8'h00, 3'd0, 9'd0,   0,   1,  8'h5A, 8'h05, 1,    0,   1,    0};
    vecs[5]  = '{0, 8'h00, 3'd0, 9'd0,   1,   0,  8'h00, 8'h05, 1,    0,   1,    0};
    vecs[6]  = '{0, 8'h00, 3'd0, 9'd0,   0,   1,  8'h43, 8'h01, 2,    0,   1,    1};
    vecs[7]  = '{1, 8'h42, 3'd7, 9'd465, 0,   0,  8'h00, 8'h03, 2,    0,   1,    0};
    vecs[8]  = '{0, 8'h00, 3'd0, 9'd0,   1,   0,  8'h00, 8'h01, 2,    1,   1,    0};
    vecs[9]  = '{0, 8'h00, 3'd0, 9'd0,   0,   1,  8'h31, 8'h01, 2,    1,   2,    0};
    vecs[10] = '{1, 8'h61, 3'd1, 9'd10,  0,   0,  8'h00, 8'h03, 2,    1,   2,    0};
    vecs[11] = '{0, 8'h00, 3'd0, 9'd0,   0,   1,  8'h61, 8'h02, 3,    1,   2,    1};
    vecs[12] = '{0, 8'h00, 3'd0, 9'd0,   0,   1,  8'h61, 8'h02, 3,    1,   3,    0};

    // Directed vector table from reset.
    doReset();
    checkOutput("reset mask", active_mask, 8'h00);
    checkOutput("reset score", score, 16'd0);
    checkOutput("reset ready", spawn_ready, 1'b1);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].sv, vecs[i].ch, vecs[i].spd, vecs[i].x, 10'd3, vecs[i].tick,
                    vecs[i].kv, vecs[i].key);
      cycle();
      checkOutput($sformatf("vec%0d mask", i), active_mask, vecs[i].exp_mask);
      checkOutput($sformatf("vec%0d score", i), score, vecs[i].exp_score);
      checkOutput($sformatf("vec%0d miss", i), miss, vecs[i].exp_miss);
      checkOutput($sformatf("vec%0d wrong", i), wrong, vecs[i].exp_wrong);
      checkOutput($sformatf("vec%0d hit_pulse", i), hit_pulse, vecs[i].exp_hit);
    end

    // Spawn then read back through the registered port.
    doReset();
    applyStimulus(1, 8'h41, 3'd2, 9'd0, 10'd10, 0, 0, 8'h00);
    cycle();
    checkOutput("seq1 mask", active_mask, 8'h01);
    idleInputs();
    rd_idx = 3'd0;
    cycle();
    checkOutput("seq1 rd_active", rd_active, 1'b1);
    checkOutput("seq1 rd_ch", rd_ch, 8'd65);
    checkOutput("seq1 rd_x", rd_x, 9'd0);
    checkOutput("seq1 rd_y", rd_y, 10'd10);
    rd_idx = 3'd1;
    cycle();
    checkOutput("seq1 rd_empty_active", rd_active, 1'b0);
    checkOutput("seq1 rd_empty_ch", rd_ch, 8'd0);

    // Bottom-line miss.
    doReset();
    applyStimulus(1, 8'h41, 3'd2, 9'd468, 10'd0, 0, 0, 8'h00);
    cycle();
    applyStimulus(0, 8'h00, 3'd0, 9'd0, 10'd0, 1, 0, 8'h00);
    cycle();
    checkOutput("seq2 miss", miss, 16'd1);
    checkOutput("seq2 mask", active_mask, 8'h00);

    // Full table, same-cycle hit frees slot 3, held spawn lands there next cycle.
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 8'h41 + 8'(i), 3'd0, 9'd0, 10'd0, 0, 0, 8'h00);
      cycle();
    end
    checkOutput("seq4 full mask", active_mask, 8'hFF);
    applyStimulus(1, 8'h5A, 3'd0, 9'd7, 10'd9, 0, 1, 8'h44);
    checkOutput("seq4 full ready", spawn_ready, 1'b0);
    cycle();
    checkOutput("seq4 freed mask", active_mask, 8'hF7);
    checkOutput("seq4 freed ready", spawn_ready, 1'b1);
    key_valid = 1'b0;
    cycle();
    checkOutput("seq4 refill mask", active_mask, 8'hFF);
    idleInputs();
    rd_idx = 3'd3;
    cycle();
    checkOutput("seq4 slot3 ch", rd_ch, 8'h5A);
    checkOutput("seq4 slot3 x", rd_x, 9'd7);

    // Key and tick together on a letter about to fall off.
    doReset();
    applyStimulus(1, 8'h42, 3'd1, 9'd469, 10'd0, 0, 0, 8'h00);
    cycle();
    applyStimulus(1, 8'h43, 3'd3, 9'd100, 10'd0, 0, 0, 8'h00);
    cycle();
    applyStimulus(0, 8'h00, 3'd0, 9'd0, 10'd0, 1, 1, 8'h42);
    cycle();
    checkOutput("seq5 score", score, 16'd1);
    checkOutput("seq5 miss", miss, 16'd0);
    checkOutput("seq5 mask", active_mask, 8'h02);
    idleInputs();
    rd_idx = 3'd1;
    cycle();
    checkOutput("seq5 slot1 x", rd_x, 9'd103);

    // Ten misses end the game; the table and counters then freeze.
    doReset();
    applyStimulus(1, 8'h51, 3'd0, 9'd0, 10'd0, 0, 0, 8'h00);
    cycle();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 8'h4D, 3'd1, 9'd469, 10'd0, 0, 0, 8'h00);
      cycle();
      applyStimulus(0, 8'h00, 3'd0, 9'd0, 10'd0, 1, 0, 8'h00);
      cycle();
    end
    checkOutput("seq6 miss", miss, 16'd10);
    checkOutput("seq6 game_over", game_over, 1'b1);
    checkOutput("seq6 ready", spawn_ready, 1'b0);
    applyStimulus(1, 8'h4D, 3'd1, 9'd469, 10'd0, 1, 1, 8'h51);
    cycle();
    key_code = 8'h58;
    cycle();
    checkOutput("seq6 frozen wrong", wrong, 16'd0);
    checkOutput("seq6 frozen score", score, 16'd0);
    checkOutput("seq6 frozen mask", active_mask, 8'h01);
    checkOutput("seq6 frozen hit", hit_pulse, 1'b0);
    checkOutput("seq6 sticky", game_over, 1'b1);
    checkOutput("seq6 rd before rst", rd_active, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("seq6 rst game_over", game_over, 1'b0);
    checkOutput("seq6 rst miss", miss, 16'd0);
    checkOutput("seq6 rst mask", active_mask, 8'h00);
    checkOutput("seq6 rst rd_active", rd_active, 1'b0);
    checkOutput("seq6 rst rd_ch", rd_ch, 8'h00);
    rst = 1'b0;

    // Randomized episodes against the reference model.
    for (int ep = 0; ep < 4; ep++) begin
      doReset();
      for (int c = 0; c < 400; c++) begin
        logic [7:0] keys [10];
        keys = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h41, 8'h42, 8'h43, 8'h44, 8'h5A, 8'h35};
        applyStimulus(1'($urandom % 2), 8'h41 + 8'($urandom % 4), 3'($urandom % 8),
                      9'($urandom_range(0, 469)), 10'($urandom % 1024),
                      1'($urandom % 8 == 0), 1'($urandom % 3 == 0), keys[$urandom % 10]);
        rd_idx = 3'($urandom % 8);
        checkOutput("rand ready", spawn_ready, model_ready());
        model_step();
        cycle();
        checkOutput("rand mask", active_mask, model_mask());
        checkOutput("rand score", score, m_score);
        checkOutput("rand miss", miss, m_miss);
        checkOutput("rand wrong", wrong, m_wrong);
        checkOutput("rand game_over", game_over, m_over);
        checkOutput("rand hit_pulse", hit_pulse, m_hit);
        checkOutput("rand rd_active", rd_active, e_rd_act);
        checkOutput("rand rd_ch", rd_ch, e_rd_ch);
        checkOutput("rand rd_x", rd_x, e_rd_x);
        checkOutput("rand rd_y", rd_y, e_rd_y);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
